onehot_gen: RTL and testbench
=============================

# onehot_gen

Registered one-hot token generator: the producing end of the one-hot vectors our detectors check. It holds a one-hot token, presents it on a valid/ready stream and rotates it one position per accepted beat in a selectable direction. A binary index can reload it at any legal cycle. It sits ahead of round-robin arbiters, slot schedulers and one-hot mux selects.

## Interface
- DW, 8: token width; legal range 2..64.
- IW, $clog2(DW): load index width (derived; do not override).
- clk_i  input  1  rising-edge clock.
- rst_ni  input  1  asynchronous, active-low reset.
- en_i  input  1  run request; level-sensitive.
- dir_i  input  1  rotation direction: 0 = toward MSB, 1 = toward LSB; sampled on each accepted beat.
- load_valid_i  input  1  load request.
- load_idx_i  input  IW  binary bit index to load.
- load_ready_o  output  1  load may be accepted this cycle.
- onehot_o  output  DW  current token (registered).
- valid_o  output  1  token beat valid (registered).
- ready_i  input  1  downstream accepts beat.
- wrap_o  output  1  one-cycle pulse: the accepted beat wrapped the token.
- bad_idx_o  output  1  one-cycle pulse: accepted load had load_idx_i >= DW.
- err_o  output  1  sticky integrity error (macro-dependent).

## Operation
- Token register tok, DW bits; onehot_o = tok.
- FSM, two states:
  - IDLE: valid_o=0. Goes to RUN when en_i=1.
  - RUN: valid_o=1. Goes to IDLE when en_i=0 and (no beat pending or beat accepted this cycle). Valid is never withdrawn while ready_i=0.
- Beat = valid_o & ready_i. On a beat, tok rotates one position per dir_i (left: MSB→bit0; right: bit0→MSB).
- wrap_o next cycle = 1 when a beat rotates bit DW-1→0 (dir 0) or bit 0→DW-1 (dir 1).
- load_ready_o = ~(valid_o & ~ready_i) (combinational). The token never changes under a stalled beat.
- Load accepted = load_valid_i & load_ready_o:
  - If idx < DW, tok ← 1<<idx.
  - Otherwise tok is unchanged and bad_idx_o pulses.
- Load and beat in the same cycle: load wins. No rotation and no wrap_o for that beat; the beat itself still counts as delivered.
- Loads are accepted in both IDLE and RUN.

## Timing
- Reset (async assert, sync release, internally synchronised deassert):
  - tok = 1 (bit 0), state IDLE, valid_o=0.
  - wrap_o=0, bad_idx_o=0, err_o=0, load_ready_o=1.
- en_i at cycle n → valid_o=1 at n+1 showing the current tok.
- Beat at cycle n → rotated token visible at n+1. valid_o stays 1 while en_i=1, so back-to-back beats give one token per cycle.
- Load accepted at n → new token visible at n+1. bad_idx_o and wrap_o are registered and assert at n+1 for exactly one cycle.
- en_i dropped while stalled: valid_o holds until the beat completes, then falls on the next cycle.
- Reset asserted mid-stream: all outputs go to reset values immediately, with no pending beat preserved.

## Configuration
- ONEHOT_GEN_CHECK_EN defined:
  - Each cycle an internal popcount check flags tok ≠ one-hot (zero or multiple bits set).
  - On detection, err_o sets (sticky until reset) and tok is forced to 1 on the next edge, overriding rotation and loads.
- ONEHOT_GEN_CHECK_EN undefined:
  - err_o tied 0, no checker logic and no recovery.
  - Corrupted tok propagates unchanged.

## Test plan
- Reset, en_i=1, ready_i=1, dir_i=0, DW=8 → onehot_o 0x01,0x02,…,0x80,0x01 on consecutive cycles; wrap_o pulses one cycle after the 0x80 beat.
- dir_i=1, start 0x01, ready_i=1 → 0x01,0x80,0x40; wrap_o pulses after the 0x01 beat.
- Token 0x04 with ready_i=0 for 3 cycles, load_valid_i=1 idx=6 throughout → onehot_o stays 0x04, valid_o stays 1, load_ready_o=0. ready_i=1 → beat taken, load accepted same cycle, next onehot_o=0x40 with no wrap_o.
- DW=6, load_idx_i=7 accepted → token unchanged, bad_idx_o=1 for one cycle. Then idx=5 → onehot_o=0x20.
- en_i dropped while stalled on 0x08 → valid_o held until ready_i=1, then valid_o=0 next cycle with onehot_o=0x10. Async reset mid-run → onehot_o=0x01, valid_o=0 immediately.
- With ONEHOT_GEN_CHECK_EN defined, force tok=0x00 (and separately 0x05) for one cycle → err_o=1 sticky and onehot_o=0x01 next cycle. Without the macro, err_o stays 0 and 0x05 persists.

Source files
------------

// File: rtl/onehot_gen.sv
// rtl/onehot_gen.sv - registered one-hot token generator on a valid/ready stream (optional checker: ONEHOT_GEN_CHECK_EN)
module onehot_gen #(
    parameter int DW = 8,
    parameter int IW = $clog2(DW)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          dir_i,
    input  logic          load_valid_i,
    input  logic [IW-1:0] load_idx_i,
    output logic          load_ready_o,
    output logic [DW-1:0] onehot_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          wrap_o,
    output logic          bad_idx_o,
    output logic          err_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DW-1:0] TOK_ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [1:0]    rst_sync_q;
    logic          rst_n_int;
    state_t        state_q;
    logic          valid_q;
    logic [DW-1:0] tok_q, tok_d;
    logic          wrap_q, wrap_d;
    logic          bad_q, bad_d;
    logic          beat;
    logic          load_acc;
    logic          idx_ok;
    logic          tok_bad;

    // Reset asserts asynchronously but releases two clocks after rst_ni rises.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_int = rst_sync_q[1];

    assign beat         = valid_q & ready_i;
    assign load_ready_o = ~(valid_q & ~ready_i);
    assign load_acc     = load_valid_i & load_ready_o;
    assign idx_ok       = ({{(32-IW){1'b0}}, load_idx_i} < 32'(DW));

`ifdef ONEHOT_GEN_CHECK_EN
    logic err_q;

    function automatic logic [7:0] popcount(input logic [DW-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < DW; i++) n = n + {7'd0, v[i]};
        return n;
    endfunction

    // Token integrity: anything other than exactly one set bit is corruption.
    always_comb begin
        tok_bad = (popcount(tok_q) != 8'd1);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int)   err_q <= 1'b0;
        else if (tok_bad) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign tok_bad = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Next token: recovery beats load, load beats rotation, a stalled beat holds.
    always_comb begin
        tok_d  = tok_q;
        wrap_d = 1'b0;
        bad_d  = 1'b0;
        if (tok_bad) begin
            tok_d = TOK_ONE;
        end else if (load_acc) begin
            if (idx_ok) tok_d = TOK_ONE << load_idx_i;
            else        bad_d = 1'b1;
        end else if (beat) begin
            if (dir_i) begin
                tok_d  = {tok_q[0], tok_q[DW-1:1]};
                wrap_d = tok_q[0];
            end else begin
                tok_d  = {tok_q[DW-2:0], tok_q[DW-1]};
                wrap_d = tok_q[DW-1];
            end
        end
    end

    // Stream FSM plus token and pulse registers; valid only drops once the beat is delivered.
    always_ff @(posedge clk_i or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            tok_q   <= TOK_ONE;
            wrap_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            tok_q  <= tok_d;
            wrap_q <= wrap_d;
            bad_q  <= bad_d;
            case (state_q)
                S_IDLE: begin
                    if (en_i) begin
                        state_q <= S_RUN;
                        valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!en_i && (!valid_q || beat)) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign onehot_o  = tok_q;
    assign valid_o   = valid_q;
    assign wrap_o    = wrap_q;
    assign bad_idx_o = bad_q;

endmodule

// File: tb/tb_onehot_gen.sv
// tb/tb_onehot_gen.sv - directed self-checking bench for onehot_gen
module tb_onehot_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, dir, lv, lr, valid, ready, wrap, bad, err;
    logic [2:0] lidx;
    logic [7:0] oh;

    logic       en6, dir6, lv6, lr6, valid6, ready6, wrap6, bad6, err6;
    logic [2:0] lidx6;
    logic [5:0] oh6;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    onehot_gen #(.DW(8)) u8 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir),
        .load_valid_i(lv), .load_idx_i(lidx), .load_ready_o(lr),
        .onehot_o(oh), .valid_o(valid), .ready_i(ready),
        .wrap_o(wrap), .bad_idx_o(bad), .err_o(err)
    );

    onehot_gen #(.DW(6)) u6 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en6), .dir_i(dir6),
        .load_valid_i(lv6), .load_idx_i(lidx6), .load_ready_o(lr6),
        .onehot_o(oh6), .valid_o(valid6), .ready_i(ready6),
        .wrap_o(wrap6), .bad_idx_o(bad6), .err_o(err6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        en = 0; dir = 0; lv = 0; lidx = 0; ready = 0;
        en6 = 0; dir6 = 0; lv6 = 0; lidx6 = 0; ready6 = 0;
        rst_n = 1'b0;
        step();
        tests++; if (oh !== 8'h01) begin fails++; $display("FAIL reset_onehot got %h want 01", oh); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        tests++; if ({wrap, bad, err} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b want 000", {wrap, bad, err}); end
        tests++; if (lr !== 1'b1) begin fails++; $display("FAIL reset_load_ready got %b want 1", lr); end
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_rotate_left();
        en = 1; ready = 1; dir = 0;
        step();
        tests++; if (valid !== 1'b1 || oh !== 8'h01) begin fails++; $display("FAIL left_start got v=%b oh=%h want v=1 oh=01", valid, oh); end
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] exp;
            exp = 8'h01 << (i % 8);
            step();
            tests++; if (oh !== exp || wrap !== (i == 8)) begin fails++; $display("FAIL left_seq%0d got oh=%h wrap=%b want oh=%h wrap=%b", i, oh, wrap, exp, (i == 8)); end
        end
    endtask

    task automatic test_rotate_right();
        en = 0;
        step();
        lv = 1; lidx = 3'd0;
        step();
        tests++; if (oh !== 8'h01 || valid !== 1'b0) begin fails++; $display("FAIL right_load got oh=%h v=%b want 01 0", oh, valid); end
        lv = 0; dir = 1; en = 1;
        step();
        tests++; if (oh !== 8'h01 || valid !== 1'b1) begin fails++; $display("FAIL right_start got oh=%h v=%b want 01 1", oh, valid); end
        step();
        tests++; if (oh !== 8'h80 || wrap !== 1'b1) begin fails++; $display("FAIL right_wrap got oh=%h wrap=%b want 80 1", oh, wrap); end
        step();
        tests++; if (oh !== 8'h40 || wrap !== 1'b0) begin fails++; $display("FAIL right_next got oh=%h wrap=%b want 40 0", oh, wrap); end
    endtask

    task automatic test_stall_load();
        en = 0; ready = 1;
        step();
        lv = 1; lidx = 3'd2;
        step();
        lv = 0; en = 1; ready = 0; dir = 0;
        step();
        lv = 1; lidx = 3'd6;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++; if (oh !== 8'h04 || valid !== 1'b1 || lr !== 1'b0) begin fails++; $display("FAIL stall%0d got oh=%h v=%b lr=%b want 04 1 0", i, oh, valid, lr); end
            step();
        end
        ready = 1;
        #1;
        tests++; if (lr !== 1'b1) begin fails++; $display("FAIL stall_release_lr got %b want 1", lr); end
        step();
        tests++; if (oh !== 8'h40 || wrap !== 1'b0 || valid !== 1'b1) begin fails++; $display("FAIL load_wins got oh=%h wrap=%b v=%b want 40 0 1", oh, wrap, valid); end
        lv = 0;
    endtask

    task automatic test_drop_en_stalled();
        lv = 1; lidx = 3'd3; ready = 1;
        step();
        tests++; if (oh !== 8'h08) begin fails++; $display("FAIL drop_setup got %h want 08", oh); end
        lv = 0; ready = 0; en = 0;
        step();
        step();
        tests++; if (valid !== 1'b1 || oh !== 8'h08) begin fails++; $display("FAIL drop_hold got v=%b oh=%h want 1 08", valid, oh); end
        ready = 1;
        step();
        tests++; if (valid !== 1'b0 || oh !== 8'h10) begin fails++; $display("FAIL drop_done got v=%b oh=%h want 0 10", valid, oh); end
    endtask

    task automatic test_async_reset();
        en = 1; ready = 1; dir = 0;
        step();
        step();
        tests++; if (oh !== 8'h20 || valid !== 1'b1) begin fails++; $display("FAIL mid_run got oh=%h v=%b want 20 1", oh, valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (oh !== 8'h01 || valid !== 1'b0 || lr !== 1'b1) begin fails++; $display("FAIL async_reset got oh=%h v=%b lr=%b want 01 0 1", oh, valid, lr); end
        en = 0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_bad_idx();
        lv6 = 1; lidx6 = 3'd7;
        step();
        tests++; if (oh6 !== 6'h01 || bad6 !== 1'b1) begin fails++; $display("FAIL bad_idx7 got oh=%h bad=%b want 01 1", oh6, bad6); end
        lidx6 = 3'd6;
        step();
        tests++; if (oh6 !== 6'h01 || bad6 !== 1'b1) begin fails++; $display("FAIL bad_idx6 got oh=%h bad=%b want 01 1", oh6, bad6); end
        lidx6 = 3'd5;
        step();
        tests++; if (oh6 !== 6'h20 || bad6 !== 1'b0) begin fails++; $display("FAIL idx5 got oh=%h bad=%b want 20 0", oh6, bad6); end
        lv6 = 0;
        step();
        tests++; if (bad6 !== 1'b0 || oh6 !== 6'h20) begin fails++; $display("FAIL bad_clear got oh=%h bad=%b want 20 0", oh6, bad6); end
    endtask

    task automatic test_corrupt(input logic [7:0] pat);
        logic [7:0] exp_oh;
        logic       exp_err;
`ifdef ONEHOT_GEN_CHECK_EN
        exp_oh = 8'h01; exp_err = 1'b1;
`else
        exp_oh = pat; exp_err = 1'b0;
`endif
        en = 0; lv = 0;
        @(negedge clk);
        force u8.tok_q = pat;
        step();
        tests++; if (err !== exp_err) begin fails++; $display("FAIL corrupt_err_%h got %b want %b", pat, err, exp_err); end
        @(negedge clk);
        release u8.tok_q;
        step();
        step();
        tests++; if (oh !== exp_oh || err !== exp_err) begin fails++; $display("FAIL corrupt_after_%h got oh=%h err=%b want %h %b", pat, oh, err, exp_oh, exp_err); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_stall_load();
        test_drop_en_stalled();
        test_async_reset();
        test_bad_idx();
        test_corrupt(8'h00);
        test_corrupt(8'h05);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
